// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: Moore control FSM for a multicycle lw/sw/add/sub/addi/beq/j datapath.
//
// Ports:
//   clk            clock, all state changes on its rising edge
//   reset          asynchronous, active-low reset
//   opcode, funct  instruction-register fields [31:26] and [5:0]
//   alu_src_a      ALU A select (0 = PC, 1 = register A)
//   alu_src_b      ALU B select (00 B, 01 const 4, 10 sign-ext, 11 sign-ext<<2)
//   alu_op         ALU function (001 add, 010 sub, 000 load A)
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if ALU zero
//   pc_source      PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   i_or_d, mem_wr, ir_write, reg_write, reg_dst, mem_to_reg   datapath controls
//   illegal        one-cycle flag for an unsupported opcode/funct
//   state          current state code, for debug
module alu_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;

    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;

    typedef enum logic [3:0] {
        StFetch     = 4'd0,
        StFetchWait = 4'd1,
        StDecode    = 4'd2,
        StMemAddr   = 4'd3,
        StMemRead   = 4'd4,
        StMemWait   = 4'd5,
        StLwWb      = 4'd6,
        StSwWrite   = 4'd7,
        StExecR     = 4'd8,
        StRWb       = 4'd9,
        StExecI     = 4'd10,
        StIWb       = 4'd11,
        StBranch    = 4'd12,
        StJump      = 4'd13,
        StErr       = 4'd14,
        StUnused    = 4'd15
    } state_e;

    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_wr;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d, ctrl_out;
    // Cleared by reset: the first edge after release re-enters FETCH so the
    // FETCH outputs appear for a full cycle instead of skipping to FETCH_WAIT.
    logic   started_q;

    // Next-state logic; opcode/funct are only looked at when leaving DECODE
    // and MEM_ADDR (funct for EXEC_R is captured on entry, see below).
    always_comb begin
        state_d = state_q;
        if (!started_q) begin
            state_d = StFetch;
        end else begin
            case (state_q)
                StFetch:     state_d = StFetchWait;
                StFetchWait: state_d = StDecode;
                StDecode: begin
                    case (opcode)
                        OpLw, OpSw: state_d = StMemAddr;
                        OpRtype:    state_d = (funct == FnAdd || funct == FnSub) ? StExecR : StErr;
                        OpAddi:     state_d = StExecI;
                        OpBeq:      state_d = StBranch;
                        OpJ:        state_d = StJump;
                        default:    state_d = StErr;
                    endcase
                end
                StMemAddr:   state_d = (opcode == OpSw) ? StSwWrite : StMemRead;
                StMemRead:   state_d = StMemWait;
                StMemWait:   state_d = StLwWb;
                StExecR:     state_d = StRWb;
                StExecI:     state_d = StIWb;
                default:     state_d = StFetch;
            endcase
        end
    end

    // Outputs are decoded from the state being entered and registered, so they
    // are glitch-free and line up with the state register.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            StFetch: begin
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.alu_op    = AluAdd;
                ctrl_d.pc_write  = 1'b1;
            end
            StFetchWait: ctrl_d.ir_write = 1'b1;
            StDecode: begin
                ctrl_d.alu_src_b = 2'b11;
                ctrl_d.alu_op    = AluAdd;
            end
            StMemAddr, StExecI: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                ctrl_d.alu_op    = AluAdd;
            end
            StMemRead, StMemWait: ctrl_d.i_or_d = 1'b1;
            StLwWb: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            StSwWrite: begin
                ctrl_d.i_or_d = 1'b1;
                ctrl_d.mem_wr = 1'b1;
            end
            StExecR: begin
                // Only reachable from DECODE, so funct here is the current instruction's.
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_op    = (funct == FnSub) ? AluSub : AluAdd;
            end
            StRWb: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
            end
            StIWb: ctrl_d.reg_write = 1'b1;
            StBranch: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_op        = AluSub;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_source     = 2'b01;
            end
            StJump: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = 2'b10;
            end
            StErr:   ctrl_d.illegal = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            started_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            ctrl_q    <= ctrl_d;
        end
    end

    // The unused code must present all-zero controls while it drains to FETCH.
    always_comb begin
        ctrl_out = ctrl_q;
        if (state_q == StUnused) begin
            ctrl_out = '0;
        end
    end

    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign pc_source     = ctrl_out.pc_source;
    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_wr        = ctrl_out.mem_wr;
    assign ir_write      = ctrl_out.ir_write;
    assign reg_write     = ctrl_out.reg_write;
    assign reg_dst       = ctrl_out.reg_dst;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign illegal       = ctrl_out.illegal;
    assign state         = state_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: scoreboard bench for alu_ctrl_fsm. The stimulus process
// pushes one hand-written expected control word per cycle; a negedge monitor
// pops and compares against the DUT outputs.
module tb_alu_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    alu_ctrl_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_wr        (mem_wr),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [20:0] sb[$];
    logic [20:0] plan[$];

    // {state, a, b, op, pw, pwc, ps, iod, mw, irw, rw, rd, m2r, ill}
    function automatic logic [20:0] v(input logic [3:0] st, input logic a, input logic [1:0] b,
                                      input logic [2:0] op, input logic pw, input logic pwc,
                                      input logic [1:0] ps, input logic iod, input logic mw,
                                      input logic irw, input logic rw, input logic rd,
                                      input logic m2r, input logic ill);
        return {st, a, b, op, pw, pwc, ps, iod, mw, irw, rw, rd, m2r, ill};
    endfunction

    logic [20:0] got;
    assign got = {state, alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, pc_source,
                  i_or_d, mem_wr, ir_write, reg_write, reg_dst, mem_to_reg, illegal};

    logic [20:0] e_z, e_f, e_fw, e_d, e_ma, e_mr, e_mw, e_lw, e_sw;
    logic [20:0] e_xa, e_xs, e_rwb, e_xi, e_iwb, e_br, e_j, e_err;

    always @(negedge clk) begin
        logic [20:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL cycle_ctrl t=%0t state got=%0d exp=%0d word got=%h exp=%h",
                         $time, got[20:17], e[20:17], got, e);
            end
        end
    end

    // Plays out the queued plan one cycle per entry. With scramble set, the
    // instruction fields carry junk except in the states that decode them.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input bit scramble);
        logic [3:0] st;
        while (plan.size() > 0) begin
            logic [20:0] e;
            e  = plan.pop_front();
            st = e[20:17];
            if (!scramble || st == 4'd2 || st == 4'd3 || st == 4'd8) begin
                opcode = op;
                funct  = fn;
            end else begin
                opcode = 6'h3F;
                funct  = 6'h2A;
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        e_z   = '0;
        e_f   = v(4'd0,  0, 2'b01, 3'b001, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        e_fw  = v(4'd1,  0, 2'b00, 3'b000, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0);
        e_d   = v(4'd2,  0, 2'b11, 3'b001, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        e_ma  = v(4'd3,  1, 2'b10, 3'b001, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        e_mr  = v(4'd4,  0, 2'b00, 3'b000, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        e_mw  = v(4'd5,  0, 2'b00, 3'b000, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        e_lw  = v(4'd6,  0, 2'b00, 3'b000, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, 0);
        e_sw  = v(4'd7,  0, 2'b00, 3'b000, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0);
        e_xa  = v(4'd8,  1, 2'b00, 3'b001, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        e_xs  = v(4'd8,  1, 2'b00, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        e_rwb = v(4'd9,  0, 2'b00, 3'b000, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0);
        e_xi  = v(4'd10, 1, 2'b10, 3'b001, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        e_iwb = v(4'd11, 0, 2'b00, 3'b000, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
        e_br  = v(4'd12, 1, 2'b00, 3'b010, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        e_j   = v(4'd13, 0, 2'b00, 3'b000, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        e_err = v(4'd14, 0, 2'b00, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);

        reset  = 1'b0;
        opcode = 6'h00;
        funct  = 6'h20;

        // In reset: state 0, all controls 0, including the cycle right after release.
        sb.push_back(e_z);
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        sb.push_back(e_z);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // add: 5 cycles
        plan = '{e_f, e_fw, e_d, e_xa, e_rwb};
        run(6'h00, 6'h20, 1'b0);
        // sub with junk fields outside the decoding states
        plan = '{e_f, e_fw, e_d, e_xs, e_rwb};
        run(6'h00, 6'h22, 1'b1);
        // lw: 7 cycles
        plan = '{e_f, e_fw, e_d, e_ma, e_mr, e_mw, e_lw};
        run(6'h23, 6'h00, 1'b1);
        // sw: 5 cycles, mem_wr in exactly one
        plan = '{e_f, e_fw, e_d, e_ma, e_sw};
        run(6'h2B, 6'h00, 1'b0);
        // addi
        plan = '{e_f, e_fw, e_d, e_xi, e_iwb};
        run(6'h08, 6'h11, 1'b1);
        // beq: 4 cycles
        plan = '{e_f, e_fw, e_d, e_br};
        run(6'h04, 6'h00, 1'b0);
        // j
        plan = '{e_f, e_fw, e_d, e_j};
        run(6'h02, 6'h00, 1'b1);
        // illegal opcode, then illegal R-type funct
        plan = '{e_f, e_fw, e_d, e_err};
        run(6'h3F, 6'h00, 1'b0);
        plan = '{e_f, e_fw, e_d, e_err};
        run(6'h00, 6'h2A, 1'b0);

        // sw aborted by reset while in SW_WRITE
        plan = '{e_f, e_fw, e_d, e_ma};
        run(6'h2B, 6'h00, 1'b0);
        sb.push_back(e_sw);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({mem_wr, state} !== 5'd0) begin
            n_fails++;
            $display("FAIL async_reset_sw got mem_wr=%0b state=%0d exp mem_wr=0 state=0",
                     mem_wr, state);
        end
        n_checks++;
        if (got !== e_z) begin
            n_fails++;
            $display("FAIL async_reset_all got=%h exp=%h", got, e_z);
        end
        @(posedge clk);
        #1;
        sb.push_back(e_z);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // first instruction after the abort starts cleanly in FETCH
        plan = '{e_f, e_fw, e_d, e_xa, e_rwb};
        run(6'h00, 6'h20, 1'b0);
        plan = '{e_f};
        run(6'h00, 6'h20, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
